// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared CPU datapath types, including the ID/EX bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int SHAM_W = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    word_t             nPC;
    regbits_t          rs;
    regbits_t          rt;
    regbits_t          regDst;
    logic              dREN;
    logic              dWEN;
    logic              regWr;
    logic [2:0]        regSel;
    aluop_t            ALUOp;
    logic [2:0]        PCSrc;
    logic [2:0]        ALUSrc;
    word_t             rdat1;
    word_t             rdat2;
    word_t             imm;
    logic              lui;
    logic [SHAM_W:0]   shamt;
    logic              halt;
  } idex_t;

  // All-zero bundle: ALUOp decodes to ALU_SLL and every enable is low.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_reg_if.sv
// ============================================================================
// id_ex_reg_if : decode-side inputs and execute-side outputs of the ID/EX stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface id_ex_reg_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             mem_busy;
  logic             flush;
  idex_t            id_in;
  idex_t            ex_out;
  logic             ex_valid;
  logic             lu_stall;
  logic             halt_out;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, mem_busy, flush, id_in,
    input  ex_out, ex_valid, lu_stall, halt_out, stall_cnt
  );

  modport slave (
    input  ihit, mem_busy, flush, id_in,
    output ex_out, ex_valid, lu_stall, halt_out, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_lu.sv
// ============================================================================
// hazard_lu : combinational load-use compare of the EX instruction against ID
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_lu
  import cpu_types_pkg::*;
(
  input  logic     ex_valid,
  input  logic     ex_dren,
  input  logic     ex_regwr,
  input  regbits_t ex_regdst,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu_stall
);

  logic w_ex_loads;
  logic w_src_match;

  // $zero is never a hazard; rt is compared even when unused by the consumer.
  assign w_ex_loads  = ex_valid & ex_dren & ex_regwr & (ex_regdst != '0);
  assign w_src_match = (ex_regdst == id_rs) | (ex_regdst == id_rt);
  assign lu_stall    = w_ex_loads & w_src_match;

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// id_ex_reg : ID/EX pipeline register with load-use bubbles, flush and halt
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_reg
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic        CLK,
  input  logic        nRST,
  id_ex_reg_if.slave  bus
);

  idex_t            r_ex;
  logic             r_valid;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu_stall;
  logic             w_adv;

  hazard_lu u_hazard_lu (
    .ex_valid  (r_valid),
    .ex_dren   (r_ex.dREN),
    .ex_regwr  (r_ex.regWr),
    .ex_regdst (r_ex.regDst),
    .id_rs     (bus.id_in.rs),
    .id_rt     (bus.id_in.rt),
    .lu_stall  (w_lu_stall)
  );

  assign w_adv = bus.ihit & ~bus.mem_busy & ~r_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ex        <= IDEX_BUBBLE;
      r_valid     <= 1'b0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (r_valid & r_ex.halt) begin
        r_halt <= 1'b1;
      end

      // A held flush is dropped; the branch unit re-asserts it when EX/MEM frees.
      if (bus.mem_busy | r_halt) begin
        r_ex    <= r_ex;
        r_valid <= r_valid;
      end else if (bus.flush) begin
        r_ex    <= IDEX_BUBBLE;
        r_valid <= 1'b0;
      end else if (w_adv & w_lu_stall) begin
        r_ex    <= IDEX_BUBBLE;
        r_valid <= 1'b0;
        if (r_stall_cnt != {CNT_W{1'b1}}) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
      end else if (w_adv) begin
        r_ex    <= bus.id_in;
        r_valid <= 1'b1;
      end else begin
        r_ex    <= IDEX_BUBBLE;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ex_out    = r_ex;
  assign bus.ex_valid  = r_valid;
  assign bus.lu_stall  = w_lu_stall;
  assign bus.halt_out  = r_halt;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// tb_id_ex_reg : directed-vector bench for id_ex_reg (CNT_W=16 and CNT_W=2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_reg;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;

  id_ex_reg_if #(.CNT_W(16)) bus  ();
  id_ex_reg_if #(.CNT_W(2))  bus2 ();

  id_ex_reg #(.CNT_W(16)) u_dut  (.CLK(CLK), .nRST(nRST), .bus(bus));
  id_ex_reg #(.CNT_W(2))  u_dut2 (.CLK(CLK), .nRST(nRST), .bus(bus2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic idex_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic dren, input logic dwen, input logic regwr,
                               input logic halt);
    idex_t t;
    t        = '0;
    t.nPC    = 32'h0000_0400 + {25'd0, rd, 2'b00};
    t.rs     = rs;
    t.rt     = rt;
    t.regDst = rd;
    t.dREN   = dren;
    t.dWEN   = dwen;
    t.regWr  = regwr;
    t.regSel = 3'd2;
    t.ALUOp  = ALU_ADD;
    t.PCSrc  = 3'd1;
    t.ALUSrc = 3'd3;
    t.rdat1  = 32'hA5A5_0000 | {27'd0, rs};
    t.rdat2  = 32'h5A5A_0000 | {27'd0, rt};
    t.imm    = 32'h0000_1234;
    t.lui    = 1'b1;
    t.shamt  = 5'd3;
    t.halt   = halt;
    return t;
  endfunction

  // One edge, then settle; every bubble must carry no enables.
  task automatic tick();
    @(posedge CLK);
    #1;
    check("bubble_inv", 256'(!bus.ex_valid && (bus.ex_out.dREN || bus.ex_out.dWEN ||
          bus.ex_out.regWr || bus.ex_out.halt)), 256'(0));
  endtask

  idex_t add3, lw5, dep5, lw7, deprt7, lw0, use0, sw5, ldnw5, use6, halt_i;

  initial begin
    add3   = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    lw5    = mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    dep5   = mk(5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    lw7    = mk(5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    deprt7 = mk(5'd1, 5'd7, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    lw0    = mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    use0   = mk(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    sw5    = mk(5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    ldnw5  = mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    use6   = mk(5'd6, 5'd6, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    halt_i = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    nRST = 1'b1;
    bus.ihit  = 1'b0; bus.mem_busy  = 1'b0; bus.flush  = 1'b0; bus.id_in  = '0;
    bus2.ihit = 1'b0; bus2.mem_busy = 1'b0; bus2.flush = 1'b0; bus2.id_in = '0;

    // Reset applies before any clock edge
    #1 nRST = 1'b0;
    #1;
    check("rst_valid", 256'(bus.ex_valid),  256'(0));
    check("rst_halt",  256'(bus.halt_out),  256'(0));
    check("rst_cnt",   256'(bus.stall_cnt), 256'(0));
    check("rst_bundle", 256'(bus.ex_out),   256'(0));
    check("rst_lu",    256'(bus.lu_stall),  256'(0));

    @(negedge CLK);
    nRST = 1'b1;

    // Pass-through
    bus.ihit  = 1'b1;
    bus.id_in = add3;
    tick();
    check("pass_bundle", 256'(bus.ex_out),   256'(add3));
    check("pass_valid",  256'(bus.ex_valid), 256'(1));
    bus.id_in = lw5;
    #1 check("pass_lu", 256'(bus.lu_stall), 256'(0));
    tick();

    // Load-use on rs
    bus.id_in = dep5;
    #1 check("lu_rs_stall", 256'(bus.lu_stall), 256'(1));
    tick();
    check("lu_bubble_valid", 256'(bus.ex_valid), 256'(0));
    check("lu_bubble_out",   256'(bus.ex_out),   256'(0));
    check("lu_cnt1",         256'(bus.stall_cnt), 256'(1));
    check("lu_after_bubble", 256'(bus.lu_stall), 256'(0));
    tick();
    check("lu_dep_latched", 256'(bus.ex_out),   256'(dep5));
    check("lu_dep_valid",   256'(bus.ex_valid), 256'(1));

    // ALU producer (no dREN) never stalls
    bus.id_in = use6;
    #1 check("alu_no_lu", 256'(bus.lu_stall), 256'(0));

    // Load-use on rt
    bus.id_in = lw7;
    tick();
    bus.id_in = deprt7;
    #1 check("lu_rt_stall", 256'(bus.lu_stall), 256'(1));
    tick();
    check("lu_cnt2", 256'(bus.stall_cnt), 256'(2));
    tick();
    check("lu_rt_latched", 256'(bus.ex_out), 256'(deprt7));

    // $zero destination, store, and non-writing load never stall
    bus.id_in = lw0;
    tick();
    bus.id_in = use0;
    #1 check("zero_no_lu", 256'(bus.lu_stall), 256'(0));
    bus.id_in = sw5;
    tick();
    bus.id_in = dep5;
    #1 check("sw_no_lu", 256'(bus.lu_stall), 256'(0));
    bus.id_in = ldnw5;
    tick();
    bus.id_in = dep5;
    #1 check("noregwr_no_lu", 256'(bus.lu_stall), 256'(0));
    tick();

    // Flush beats load-use and does not count
    bus.id_in = lw5;
    tick();
    bus.id_in = dep5;
    bus.flush = 1'b1;
    #1 check("flush_lu_high", 256'(bus.lu_stall), 256'(1));
    tick();
    check("flush_valid", 256'(bus.ex_valid),  256'(0));
    check("flush_out",   256'(bus.ex_out),    256'(0));
    check("flush_cnt",   256'(bus.stall_cnt), 256'(2));

    // mem_busy holds state even with flush asserted
    bus.flush = 1'b0;
    bus.id_in = add3;
    tick();
    bus.mem_busy = 1'b1;
    bus.flush    = 1'b1;
    bus.id_in    = lw7;
    tick();
    check("busy_hold_out",   256'(bus.ex_out),   256'(add3));
    check("busy_hold_valid", 256'(bus.ex_valid), 256'(1));

    // mem_busy also suppresses a pending load-use bubble
    bus.mem_busy = 1'b0;
    bus.flush    = 1'b0;
    bus.id_in    = lw5;
    tick();
    bus.id_in    = dep5;
    bus.mem_busy = 1'b1;
    tick();
    check("busy_lu_hold", 256'(bus.ex_out),    256'(lw5));
    check("busy_lu_cnt",  256'(bus.stall_cnt), 256'(2));
    bus.mem_busy = 1'b0;
    tick();
    check("busy_released_cnt", 256'(bus.stall_cnt), 256'(3));
    tick();
    check("busy_released_dep", 256'(bus.ex_out), 256'(dep5));

    // Fetch miss loads a bubble
    bus.ihit = 1'b0;
    tick();
    check("miss_valid", 256'(bus.ex_valid), 256'(0));
    check("miss_out",   256'(bus.ex_out),   256'(0));

    // Sticky halt
    bus.ihit  = 1'b1;
    bus.id_in = halt_i;
    tick();
    check("halt_in_ex",  256'(bus.ex_out.halt), 256'(1));
    check("halt_not_yet", 256'(bus.halt_out),   256'(0));
    bus.id_in = add3;
    tick();
    check("halt_set",   256'(bus.halt_out), 256'(1));
    check("halt_edge_load", 256'(bus.ex_out), 256'(add3));
    bus.id_in = lw7;
    tick();
    tick();
    check("halt_frozen", 256'(bus.ex_out),   256'(add3));
    check("halt_sticky", 256'(bus.halt_out), 256'(1));
    check("halt_cnt",    256'(bus.stall_cnt), 256'(3));

    // Reset asserted mid-cycle clears state before the next edge
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_valid", 256'(bus.ex_valid),  256'(0));
    check("mid_rst_halt",  256'(bus.halt_out),  256'(0));
    check("mid_rst_cnt",   256'(bus.stall_cnt), 256'(0));
    check("mid_rst_lu",    256'(bus.lu_stall),  256'(0));
    @(negedge CLK);
    nRST      = 1'b1;
    bus.id_in = add3;
    tick();
    check("post_rst_load", 256'(bus.ex_out), 256'(add3));

    // Two-bit counter saturates at 3
    bus.ihit  = 1'b0;
    bus2.ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.id_in = lw5;
      tick();
      bus2.id_in = dep5;
      tick();
      check($sformatf("sat_cnt_%0d", i), 256'(bus2.stall_cnt), 256'((i < 3) ? i + 1 : 3));
    end
    check("sat_bubble", 256'(bus2.ex_valid), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
